// File: rtl/coherency_pkg.sv
// rtl/coherency_pkg.sv - coherency bus state encoding and limits
package coherency_pkg;
  import cpu_types_pkg::*;

  localparam int MAX_NCPU = 8;

  typedef logic [2:0] bus_state_t;

  localparam bus_state_t IDLE   = 3'd0;
  localparam bus_state_t IFETCH = 3'd1;
  localparam bus_state_t WB     = 3'd2;
  localparam bus_state_t SNOOP  = 3'd3;
  localparam bus_state_t C2C    = 3'd4;
  localparam bus_state_t M2C    = 3'd5;

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM interface types
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting at ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  // Scan from the farthest offset down so the core nearest ptr overwrites last.
  always_comb begin
    gnt = '0;
    for (int off = N - 1; off >= 0; off--) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && (k == ((int'(ptr) + off) % N))) begin
          gnt    = '0;
          gnt[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/coherency_bus_n.sv
// rtl/coherency_bus_n.sv - N-core snooping coherency bus and RAM arbiter
module coherency_bus_n
  import cpu_types_pkg::*;
  import coherency_pkg::*;
#(
  parameter int NCPU      = 2,
  parameter int AW        = 32,
  parameter int SNOOP_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCPU-1:0]    iREN,
  input  logic [NCPU*AW-1:0] iaddr,
  output logic [NCPU-1:0]    iwait,
  output logic [NCPU*AW-1:0] iload,
  input  logic [NCPU-1:0]    dREN,
  input  logic [NCPU-1:0]    dWEN,
  input  logic [NCPU*AW-1:0] daddr,
  input  logic [NCPU*AW-1:0] dstore,
  input  logic [NCPU-1:0]    ccwrite,
  input  logic [NCPU-1:0]    cctrans,
  output logic [NCPU-1:0]    dwait,
  output logic [NCPU*AW-1:0] dload,
  output logic [NCPU-1:0]    ccwait,
  output logic [NCPU-1:0]    ccinv,
  output logic [NCPU*AW-1:0] ccsnoopaddr,
  input  ramstate_t          ramstate,
  input  logic [AW-1:0]      ramload,
  output logic [AW-1:0]      ramaddr,
  output logic [AW-1:0]      ramstore,
  output logic               ramREN,
  output logic               ramWEN
);

  localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CW = $clog2(SNOOP_LAT + 1);

  bus_state_t      state;
  logic [NCPU-1:0] gnt;
  logic [NCPU-1:0] sup;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic [NCPU-1:0] dgnt, ignt, hits;
  logic [PW-1:0]   nxt_ptr;
  logic            ready, g_ireq, g_dren, g_dwen, g_ccwrite;
  logic [AW-1:0]   g_iaddr, g_daddr, g_dstore, s_data;

  rr_arbiter #(.N(NCPU), .PW(PW)) u_darb (.req(dREN | dWEN), .ptr(ptr), .gnt(dgnt));
  rr_arbiter #(.N(NCPU), .PW(PW)) u_iarb (.req(iREN),        .ptr(ptr), .gnt(ignt));

  assign ready = (ramstate == ACCESS) || (ramstate == FREE);
  assign hits  = cctrans & ~gnt;

  // Everything about the granted core and the supplier, selected by one-hot masks.
  always_comb begin
    g_ireq    = |(iREN & gnt);
    g_dren    = |(dREN & gnt);
    g_dwen    = |(dWEN & gnt);
    g_ccwrite = |(ccwrite & gnt);
    g_iaddr   = '0;
    g_daddr   = '0;
    g_dstore  = '0;
    s_data    = '0;
    nxt_ptr   = '0;
    for (int k = 0; k < NCPU; k++) begin
      if (gnt[k]) begin
        g_iaddr  = iaddr[k*AW +: AW];
        g_daddr  = daddr[k*AW +: AW];
        g_dstore = dstore[k*AW +: AW];
        nxt_ptr  = PW'((k + 1) % NCPU);
      end
      if (sup[k]) s_data = dstore[k*AW +: AW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      sup   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(dREN | dWEN)) begin
            gnt <= dgnt;
            if (|(dWEN & dgnt)) begin
              state <= WB;
            end else if (NCPU == 1) begin
              state <= M2C;
            end else begin
              state <= SNOOP;
              cnt   <= '0;
            end
          end else if (|iREN) begin
            gnt   <= ignt;
            state <= IFETCH;
          end
        end
        SNOOP: begin
          if (cnt == CW'(SNOOP_LAT - 1)) begin
            cnt <= '0;
            if (|hits) begin
              sup   <= hits & (~hits + 1'b1);
              state <= C2C;
            end else begin
              state <= M2C;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IFETCH: if (!g_ireq) begin state <= IDLE; ptr <= nxt_ptr; end
        WB:     if (!g_dwen) begin state <= IDLE; ptr <= nxt_ptr; end
        C2C,
        M2C:    if (!g_dren) begin state <= IDLE; ptr <= nxt_ptr; end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    case (state)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = g_iaddr;
        for (int k = 0; k < NCPU; k++) begin
          if (gnt[k]) begin
            iload[k*AW +: AW] = ramload;
            iwait[k]          = !ready;
          end
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = g_daddr;
        ramstore = g_dstore;
        for (int k = 0; k < NCPU; k++) begin
          if (gnt[k]) dwait[k] = !ready;
        end
      end
      SNOOP: begin
        for (int k = 0; k < NCPU; k++) begin
          if (!gnt[k]) begin
            ccwait[k]               = 1'b1;
            ccinv[k]                = g_ccwrite;
            ccsnoopaddr[k*AW +: AW] = g_daddr;
          end
        end
      end
      C2C: begin
        // Peer supplies the word; RAM is refreshed with it in the same beat.
        ramWEN   = 1'b1;
        ramaddr  = g_daddr;
        ramstore = s_data;
        for (int k = 0; k < NCPU; k++) begin
          if (gnt[k]) begin
            dload[k*AW +: AW] = s_data;
            dwait[k]          = !ready;
          end
          if (sup[k]) begin
            ccwait[k] = 1'b1;
            dwait[k]  = !ready;
          end
        end
      end
      M2C: begin
        ramREN  = 1'b1;
        ramaddr = g_daddr;
        for (int k = 0; k < NCPU; k++) begin
          if (gnt[k]) begin
            dload[k*AW +: AW] = ramload;
            dwait[k]          = !ready;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherency_bus_n.sv
// tb/tb_coherency_bus_n.sv - directed checks of coherency_bus_n (NCPU=4 and NCPU=1)
module tb_coherency_bus_n;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [3:0]   iREN, dREN, dWEN, ccwrite, cctrans;
  logic [127:0] iaddr, daddr, dstore;
  logic [3:0]   iwait, dwait, ccwait, ccinv;
  logic [127:0] iload, dload, ccsnoopaddr;
  ramstate_t    ramstate;
  logic [31:0]  ramload, ramaddr, ramstore;
  logic         ramREN, ramWEN;

  logic         iREN1, dREN1, dWEN1, ccwrite1, cctrans1;
  logic [31:0]  iaddr1, daddr1, dstore1;
  logic         iwait1, dwait1, ccwait1, ccinv1;
  logic [31:0]  iload1, dload1, ccsnoopaddr1;
  logic [31:0]  ramaddr1, ramstore1;
  logic         ramREN1, ramWEN1;

  coherency_bus_n #(.NCPU(4), .AW(32), .SNOOP_LAT(2)) dut4 (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
    .cctrans(cctrans), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
  );

  coherency_bus_n #(.NCPU(1), .AW(32), .SNOOP_LAT(2)) dut1 (
    .CLK(CLK), .RST(RST), .iREN(iREN1), .iaddr(iaddr1), .iwait(iwait1), .iload(iload1),
    .dREN(dREN1), .dWEN(dWEN1), .daddr(daddr1), .dstore(dstore1), .ccwrite(ccwrite1),
    .cctrans(cctrans1), .dwait(dwait1), .dload(dload1), .ccwait(ccwait1), .ccinv(ccinv1),
    .ccsnoopaddr(ccsnoopaddr1), .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr1),
    .ramstore(ramstore1), .ramREN(ramREN1), .ramWEN(ramWEN1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    iREN1 = 0; dREN1 = 0; dWEN1 = 0; ccwrite1 = 0; cctrans1 = 0;
    iaddr1 = '0; daddr1 = '0; dstore1 = '0;
    ramstate = ACCESS;
    ramload = 32'h1234;
    tick(2);
    RST = 1'b0;
    check("rst_iwait", iwait, 4'hf);
    check("rst_dwait", dwait, 4'hf);
    check("rst_ramren", ramREN, 1'b0);
    check("rst_ccwait", ccwait, 4'h0);

    // instruction round robin: core1 then core3, pointer wraps to 0
    iaddr[63:32] = 32'h100;
    iaddr[127:96] = 32'h300;
    iREN = 4'b1010;
    tick(1);
    check("if1_iwait", iwait, 4'b1101);
    check("if1_ramaddr", ramaddr, 32'h100);
    check("if1_ramren", ramREN, 1'b1);
    check("if1_iload", iload[63:32], 32'h1234);
    iREN = 4'b1000;
    tick(1);
    check("if_idle_iwait", iwait, 4'hf);
    tick(1);
    check("if3_iwait", iwait, 4'b0111);
    check("if3_ramaddr", ramaddr, 32'h300);
    iREN = 4'b0000;
    tick(1);
    iREN = 4'b1111;
    tick(1);
    check("ptr0_iwait", iwait, 4'b1110);
    iREN = 4'b0000;
    tick(1);

    // data beats instruction; pointer now 1
    daddr[95:64] = 32'h200;
    dREN = 4'b0100;
    iREN = 4'b0001;
    tick(1);
    check("d2_snoop_ccwait", ccwait, 4'b1011);
    check("d2_snoop_iwait", iwait, 4'hf);
    tick(2);
    check("d2_m2c_dwait", dwait, 4'b1011);
    check("d2_m2c_ramaddr", ramaddr, 32'h200);
    check("d2_m2c_ramren", ramREN, 1'b1);
    check("d2_m2c_dload", dload[95:64], 32'h1234);
    check("d2_m2c_iwait0", iwait[0], 1'b1);
    dREN = 4'b0000;
    tick(1);
    check("d2_idle_iwait0", iwait[0], 1'b1);
    tick(1);
    check("if0_after_data", iwait, 4'b1110);
    iREN = 4'b0000;
    tick(1);

    // read-exclusive snoop hitting modified copy in core3
    daddr[31:0] = 32'h40;
    dstore[127:96] = 32'hDEAD;
    dREN = 4'b0001;
    ccwrite = 4'b0001;
    cctrans = 4'b1000;
    tick(1);
    check("c2c_snoop_ccinv", ccinv, 4'b1110);
    check("c2c_snoop_addr", ccsnoopaddr[127:96], 32'h40);
    check("c2c_snoop_addr0", ccsnoopaddr[31:0], 32'h0);
    tick(1);
    check("c2c_snoop2_ccwait", ccwait, 4'b1110);
    tick(1);
    check("c2c_dload", dload[31:0], 32'hDEAD);
    check("c2c_ramwen", ramWEN, 1'b1);
    check("c2c_ramaddr", ramaddr, 32'h40);
    check("c2c_ramstore", ramstore, 32'hDEAD);
    check("c2c_dwait", dwait, 4'b0110);
    check("c2c_ccwait", ccwait, 4'b1000);
    check("c2c_ramren", ramREN, 1'b0);

    // reset mid-transaction
    RST = 1'b1;
    tick(1);
    check("mid_rst_ramwen", ramWEN, 1'b0);
    check("mid_rst_ramren", ramREN, 1'b0);
    check("mid_rst_ccwait", ccwait, 4'h0);
    check("mid_rst_dwait", dwait, 4'hf);
    check("mid_rst_iwait", iwait, 4'hf);
    RST = 1'b0;
    dREN = '0; ccwrite = '0; cctrans = '0;
    tick(1);

    // M2C stalled by BUSY RAM
    daddr[63:32] = 32'h80;
    dREN = 4'b0010;
    ramstate = BUSY;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("busy%0d_dwait1", i), dwait[1], 1'b1);
      check($sformatf("busy%0d_ramren", i), ramREN, 1'b1);
    end
    ramstate = ACCESS;
    ramload = 32'h5678;
    tick(1);
    check("busy_done_dwait1", dwait[1], 1'b0);
    check("busy_done_ramren", ramREN, 1'b1);
    check("busy_done_dload", dload[63:32], 32'h5678);
    check("busy_done_ramaddr", ramaddr, 32'h80);
    dREN = '0;
    tick(1);
    check("busy_exit_ramren", ramREN, 1'b0);

    // single core: IDLE goes straight to M2C
    daddr1 = 32'h44;
    dREN1 = 1'b1;
    tick(1);
    check("n1_ramren", ramREN1, 1'b1);
    check("n1_dwait", dwait1, 1'b0);
    check("n1_ccwait", ccwait1, 1'b0);
    check("n1_ramaddr", ramaddr1, 32'h44);
    check("n1_dload", dload1, 32'h5678);
    dREN1 = 1'b0;
    tick(1);
    check("n1_idle_dwait", dwait1, 1'b1);
    check("n1_idle_ramren", ramREN1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
